// File: rtl/fpa_operand_seq_pkg.sv
// fpa_operand_seq_pkg: shared FSM state encoding and default WIDTH/TIMEOUT for the FP adder operand sequencer
package fpa_operand_seq_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_TIMEOUT = 64;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_LATCH  = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/fpa_operand_seq_bit_counter.sv
// fpa_operand_seq_bit_counter: serial bit index (clk, rst, clr, en -> cnt, last), counts 0..N-1 and wraps
module fpa_operand_seq_bit_counter #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);
  assign last = cnt == W'(N - 1);
  always_ff @(posedge clk) cnt <= rst || clr ? '0 : en ? (last ? '0 : cnt + 1'b1) : cnt;
endmodule

// File: rtl/fpa_operand_seq.sv
// fpa_operand_seq: serial operand A/B load, latch, adder start and result handshake (clk_in, rst_in active-low sync, strobes out, done/ack in)
module fpa_operand_seq
  import fpa_operand_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W = $clog2(WIDTH),
  localparam int TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             abort_in,
  output logic             sr_a_wr_out,
  output logic             sr_b_wr_out,
  output logic             sr_en_out,
  output logic             add_start_out,
  input  logic             add_done_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] bit_idx_out,
  output logic             result_valid_out,
  output logic             error_out,
  input  logic             result_ack_in
);
  state_t state, nxt;
  logic [TO_W-1:0] to_q;
  logic err_q, bit_last, loading, timed_out;
  assign loading = state == ST_LOAD_A || state == ST_LOAD_B;
  assign timed_out = to_q == TO_W'(TIMEOUT - 1);
  fpa_operand_seq_bit_counter #(.N(WIDTH)) u_bit (
    .clk(clk_in),
    .rst(!rst_in),
    .clr(abort_in || !loading),
    .en(loading),
    .cnt(bit_idx_out),
    .last(bit_last)
  );
  always_ff @(posedge clk_in) state <= rst_in ? nxt : ST_IDLE;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = start_in ? ST_LOAD_A : ST_IDLE;
      ST_LOAD_A: nxt = bit_last ? ST_LOAD_B : ST_LOAD_A;
      ST_LOAD_B: nxt = bit_last ? ST_LATCH : ST_LOAD_B;
      ST_LATCH:  nxt = ST_START;
      ST_START:  nxt = ST_WAIT;
      ST_WAIT:   nxt = add_done_in || timed_out ? ST_DONE : ST_WAIT;
      ST_DONE:   nxt = result_ack_in ? ST_IDLE : ST_DONE;
      default:   nxt = ST_IDLE;
    endcase
    if (abort_in && state != ST_IDLE) nxt = ST_IDLE;
  end
  always_comb begin
    ready_out = state == ST_IDLE;
    busy_out = state != ST_IDLE && state != ST_DONE;
    sr_a_wr_out = state == ST_LOAD_A;
    sr_b_wr_out = state == ST_LOAD_B;
    sr_en_out = state == ST_LATCH;
    add_start_out = state == ST_START;
    result_valid_out = state == ST_DONE;
    error_out = err_q;
  end
  // to_q counts completed WAIT cycles; a done pulse on the last one still wins over the timeout
  always_ff @(posedge clk_in) begin
    to_q <= rst_in && state == ST_WAIT && nxt == ST_WAIT ? to_q + 1'b1 : '0;
    err_q <= !rst_in ? 1'b0 : state == ST_WAIT ? nxt == ST_DONE && !add_done_in : state == ST_DONE && nxt == ST_DONE && err_q;
  end
endmodule

// File: tb/tb_fpa_operand_seq.sv
// tb_fpa_operand_seq: directed plus random stimulus checked every cycle against a transaction-age model
module tb_fpa_operand_seq;
  localparam int W = 16;
  localparam int TO = 64;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, done = 0, ack = 0;
  logic wa, wb, en, ast, rdy, bsy, vld, err;
  logic [3:0] idx;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_en = 0, n_st = 0;
  bit chk_en = 0;
  bit m_act = 0, m_done = 0, m_err = 0;
  int m_age = 0;
  always #5 clk = ~clk;
  fpa_operand_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .abort_in(abort),
    .sr_a_wr_out(wa), .sr_b_wr_out(wb), .sr_en_out(en), .add_start_out(ast),
    .add_done_in(done), .ready_out(rdy), .busy_out(bsy), .bit_idx_out(idx),
    .result_valid_out(vld), .error_out(err), .result_ack_in(ack)
  );
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_err = 0; m_age = 0;
    end else if (m_act) begin
      if (abort) m_act = 0;
      else if (m_age >= 2 * W + 3) begin
        if (done) begin m_act = 0; m_done = 1; m_err = 0; end
        else if (m_age - (2 * W + 2) == TO) begin m_act = 0; m_done = 1; m_err = 1; end
        else m_age++;
      end else m_age++;
    end else if (m_done) begin
      if (abort || ack) begin m_done = 0; m_err = 0; end
    end else if (start) begin
      m_act = 1; m_age = 1;
    end
  end
  always @(negedge clk) begin
    logic [11:0] exp_v, act_v;
    logic e_a, e_b;
    if (en) n_en++;
    if (ast) n_st++;
    if (chk_en) begin
      e_a = m_act && m_age <= W;
      e_b = m_act && m_age > W && m_age <= 2 * W;
      exp_v = {!m_act && !m_done, m_act, e_a, e_b, m_act && m_age == 2 * W + 1,
               m_act && m_age == 2 * W + 2, m_done, m_done && m_err,
               e_a ? 4'(m_age - 1) : e_b ? 4'(m_age - W - 1) : 4'd0};
      act_v = {rdy, bsy, wa, wb, en, ast, vld, err, idx};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle %0d outputs {rdy,bsy,wa,wb,en,ast,vld,err,idx}: got %b want %b", cyc, act_v, exp_v);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_neg(input string nm, input int what);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = what == 0 ? ast : what == 1 ? vld : what == 2 ? (wb && idx == 4'd6) : wa;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: condition not reached within 300 cycles", nm);
    end
  endtask
  initial begin
    int na, nb, en_c, st_c, v, ev, ts, tv, p_en, p_st;
    rst_n = 0;
    step();
    chk_en = 1;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("reset_ready", rdy, 1);
    chk("reset_outs", {bsy, wa, wb, en, ast, vld, err, idx}, 0);
    na = 0; nb = 0; en_c = 0; st_c = 0;
    step(); start = 1; step(); start = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (wa) na++;
      if (wb) nb++;
      if (en) en_c = c;
      if (ast) st_c = c;
    end
    chk("t1_a_cycles", na, 16);
    chk("t1_b_cycles", nb, 16);
    chk("t1_latch_cycle", en_c, 33);
    chk("t1_start_cycle", st_c, 34);
    step();
    repeat (4) step();
    done = 1; step(); done = 0;
    v = 0; ev = 0;
    @(negedge clk); v += int'(vld); ev |= int'(err);
    step();
    @(negedge clk); v += int'(vld); ev |= int'(err);
    step(); ack = 1;
    @(negedge clk); v += int'(vld); ev |= int'(err);
    step(); ack = 0;
    @(negedge clk);
    chk("t2_valid_cycles", v, 3);
    chk("t2_error", ev, 0);
    chk("t2_ready_after", rdy, 1);
    chk("t2_valid_cleared", vld, 0);
    step(); start = 1; step(); start = 0;
    wait_neg("t3_start", 0);
    ts = cyc;
    wait_neg("t3_valid", 1);
    tv = cyc;
    chk("t3_wait_cycles", tv - ts - 1, 64);
    chk("t3_timeout_err", err, 1);
    step(); ack = 1; step(); ack = 0;
    start = 1; step(); start = 0;
    wait_neg("t3b_start", 0);
    step();
    repeat (63) step();
    done = 1; step(); done = 0;
    @(negedge clk);
    chk("t3b_valid", vld, 1);
    chk("t3b_done_wins", err, 0);
    step(); ack = 1; step(); ack = 0;
    start = 1; step(); start = 0;
    p_en = n_en; p_st = n_st;
    wait_neg("t4_bit6", 2);
    step(); abort = 1; step(); abort = 0;
    @(negedge clk);
    chk("t4_ready", rdy, 1);
    repeat (40) step();
    chk("t4_no_latch", n_en - p_en, 0);
    chk("t4_no_start", n_st - p_st, 0);
    start = 1;
    p_st = n_st;
    step();
    wait_neg("t5_load_a", 3);
    step(); done = 1; step(); done = 0;
    wait_neg("t5_valid", 1);
    chk("t5_one_op", n_st - p_st, 1);
    chk("t5_spurious_done_ignored", err, 1);
    repeat (5) step();
    @(negedge clk);
    chk("t5_still_valid", vld, 1);
    step(); ack = 1; step(); ack = 0;
    @(negedge clk);
    chk("t5_idle_after_ack", rdy, 1);
    step();
    @(negedge clk);
    chk("t5_next_op", wa, 1);
    start = 0;
    step(); abort = 1; step(); abort = 0;
    start = 1; step(); start = 0;
    wait_neg("t6_start", 0);
    step(); step();
    rst_n = 0; step(); rst_n = 1;
    @(negedge clk);
    chk("t6_ready", rdy, 1);
    chk("t6_outs", {bsy, wa, wb, en, ast, vld, err, idx}, 0);
    repeat (3000) begin
      step();
      start = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 79) == 0;
      done = $urandom_range(0, 24) == 0;
      ack = $urandom_range(0, 3) == 0;
      rst_n = $urandom_range(0, 599) != 0;
    end
    step();
    start = 0; abort = 0; done = 0; ack = 0; rst_n = 1;
    step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
